zbuffer_ctrl: RTL and testbench
===============================

Name: zbuffer_ctrl

Overview:
Depth-test controller that owns the z-buffer memory. It accepts one pixel at a time from the contention tree through the rdy_z_buffer/send_z_buffer handshake and performs a read-compare-conditional-write on the depth/colour RAM. It also sequences full-buffer clear sweeps. It sits between the contention tree output and a single-port synchronous RAM.

Parameters:
ADDR_WIDTH, 8, pixel address width; the buffer holds 2^ADDR_WIDTH entries.
DEPTH_WIDTH, 8, z value width. Smaller z is closer.
COLOR_WIDTH, 8, colour width.
PIXEL_WIDTH, ADDR_WIDTH+DEPTH_WIDTH+COLOR_WIDTH, packed pixel width. Derived; must not be overridden.
CLEAR_COLOR, 0, colour written during a clear.
CLEAR_ON_RESET, 1, when 1, a clear sweep starts automatically after reset.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
pix_in  in  PIXEL_WIDTH  packed {addr, z, color}; valid when send_z_buffer=1.
send_z_buffer  in  1  tree presents a pixel.
rdy_z_buffer  out  1  controller can accept a pixel.
clear_start  in  1  single-cycle request for a full clear.
clear_busy  out  1  clear sweep in progress.
mem_addr  out  ADDR_WIDTH  RAM address.
mem_rd_en  out  1  RAM read strobe. Data returns on mem_rdata the next cycle.
mem_rdata  in  DEPTH_WIDTH+COLOR_WIDTH  RAM read data, packed {z, color}.
mem_wr_en  out  1  RAM write strobe.
mem_wdata  out  DEPTH_WIDTH+COLOR_WIDTH  RAM write data, packed {z, color}.
cnt_written  out  16  pixels that passed the depth test.
cnt_rejected  out  16  pixels that failed the depth test.

Behaviour:
- Reset: all outputs 0, counters 0, clear_pending 0.
  - CLEAR_ON_RESET=1: state CLEAR, sweep address 0.
  - CLEAR_ON_RESET=0: state IDLE.
  - Reset asserted mid-operation aborts any transaction or sweep immediately.
- States: IDLE, READ, COMPARE, WRITE, CLEAR.
- Outputs are registered. rdy_z_buffer = (state==IDLE && !clear_pending && !clear_start).
- Handshake: a pixel is accepted on a cycle with rdy_z_buffer && send_z_buffer (cycle T).
  - pix_in is latched in T.
  - rdy_z_buffer is 0 from T+1 until the transaction finishes.
  - send_z_buffer while rdy_z_buffer=0 is ignored.
- IDLE:
  - clear_start or clear_pending -> CLEAR (priority over a new pixel).
  - Otherwise, on handshake -> READ.
- READ (T+1): mem_rd_en=1, mem_addr = latched addr -> COMPARE.
- COMPARE (T+2): mem_rdata valid.
  - If z_new < z_old (strict, unsigned) -> WRITE.
  - Else cnt_rejected++ and -> IDLE. Equal depth is rejected.
- WRITE (T+3): mem_wr_en=1, mem_addr = addr, mem_wdata = {z_new, color_new}, cnt_written++ -> IDLE.
- Latency: rdy_z_buffer returns high at T+3 for a rejected pixel and at T+4 for a written pixel.
- clear_start arriving outside IDLE sets clear_pending. It is serviced on the next IDLE before any new pixel. Multiple requests merge into one clear.
- CLEAR: one write per cycle.
  - mem_wr_en=1, mem_addr = sweep counter 0..2^ADDR_WIDTH-1, mem_wdata = {all ones, CLEAR_COLOR}.
  - clear_busy=1 for exactly 2^ADDR_WIDTH cycles.
  - On the last address the counter wraps to 0, clear_busy=0, clear_pending=0 -> IDLE.
  - clear_start during CLEAR is ignored.
- mem_rd_en and mem_wr_en are never high in the same cycle. mem_rd_en is 0 outside READ.
- Counters saturate at 0xFFFF. They are cleared only by reset, not by clear sweeps.
- mem_addr and mem_wdata are 0 whenever no strobe is active.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=8 -> clear_busy high 256 cycles, 256 writes of {0xFF, 0x00} to addresses 0..255, then rdy_z_buffer=1.
- After clear, send {addr=0x10, z=0x40, c=0xAA} -> read at T+1, write {0x40, 0xAA} to 0x10 at T+3, cnt_written=1, rdy_z_buffer high at T+4.
- Then send {0x10, z=0x40, c=0x55} (equal depth) and {0x10, z=0x50, c=0x55} -> no write, cnt_rejected=2, rdy_z_buffer high at T+3 for each; then {0x10, z=0x3F, c=0x55} -> written.
- Hold send_z_buffer high continuously with four pixels queued by the tree -> exactly one acceptance per transaction; no acceptance while rdy_z_buffer=0.
- Pulse clear_start during COMPARE of a passing pixel -> WRITE completes, then CLEAR starts the next cycle with no new pixel accepted; a second clear_start during CLEAR does not extend the sweep.
- Assert reset during WRITE and again mid-CLEAR at address 0x80 -> next cycle all outputs 0, counters 0, sweep restarts from 0.

Source files
------------

// File: rtl/zbuffer_ctrl_if.sv
// Bundles the signals between zbuffer_ctrl and the blocks around it. These are
// the pixel handshake from the contention tree, the clear request and status,
// the single-port RAM bus, and the depth-test counters.
//   slave  : the controller side (zbuffer_ctrl)
//   master : the environment side (tree, RAM, observers)
interface zbuffer_ctrl_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8,
  parameter int COLOR_WIDTH = 8
);
  localparam int PIXEL_WIDTH = ADDR_WIDTH + DEPTH_WIDTH + COLOR_WIDTH;
  localparam int DATA_WIDTH  = DEPTH_WIDTH + COLOR_WIDTH;

  logic [PIXEL_WIDTH-1:0] pix_in;        // {addr, z, color}
  logic                   send_z_buffer; // tree presents a pixel
  logic                   rdy_z_buffer;  // controller can accept a pixel
  logic                   clear_start;   // single-cycle clear request
  logic                   clear_busy;    // clear sweep in progress
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd_en;     // read data returns next cycle
  logic [DATA_WIDTH-1:0]  mem_rdata;     // {z, color}
  logic                   mem_wr_en;
  logic [DATA_WIDTH-1:0]  mem_wdata;     // {z, color}
  logic [15:0]            cnt_written;
  logic [15:0]            cnt_rejected;

  modport slave (
    input  pix_in, send_z_buffer, clear_start, mem_rdata,
    output rdy_z_buffer, clear_busy, mem_addr, mem_rd_en, mem_wr_en,
           mem_wdata, cnt_written, cnt_rejected
  );

  modport master (
    output pix_in, send_z_buffer, clear_start, mem_rdata,
    input  rdy_z_buffer, clear_busy, mem_addr, mem_rd_en, mem_wr_en,
           mem_wdata, cnt_written, cnt_rejected
  );
endinterface

// File: rtl/zbuffer_ctrl.sv
// Depth-test controller that owns the z-buffer RAM.
// For each accepted pixel it reads the stored {z, color}. If the new z is
// strictly smaller, it writes the new {z, color}; otherwise it rejects the
// pixel. It also runs full-buffer clear sweeps that write {all ones,
// CLEAR_COLOR} to every address, one address per cycle.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : zbuffer_ctrl_if.slave (pixel handshake, clear control, RAM bus,
//           written/rejected counters)
module zbuffer_ctrl #(
  parameter int                     ADDR_WIDTH     = 8,
  parameter int                     DEPTH_WIDTH    = 8,
  parameter int                     COLOR_WIDTH    = 8,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR    = '0,
  parameter bit                     CLEAR_ON_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  zbuffer_ctrl_if.slave  bus
);
  localparam int PIXEL_WIDTH = ADDR_WIDTH + DEPTH_WIDTH + COLOR_WIDTH;
  localparam int DATA_WIDTH  = DEPTH_WIDTH + COLOR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_COMPARE,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t                  r_state;
  logic                    r_rdy;
  logic                    r_pending;
  logic                    r_busy;
  logic                    r_rd_en;
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [ADDR_WIDTH-1:0]   r_sweep;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DEPTH_WIDTH-1:0]  r_z;
  logic [COLOR_WIDTH-1:0]  r_color;
  logic [15:0]             r_cnt_written;
  logic [15:0]             r_cnt_rejected;

  logic                    w_clear_req;
  logic                    w_accept;
  logic                    w_pass;
  logic                    w_last;
  logic                    w_enter_clear;
  logic [DEPTH_WIDTH-1:0]  w_z_old;
  logic [DATA_WIDTH-1:0]   w_clear_word;

  assign w_clear_req  = r_pending | bus.clear_start;
  assign w_z_old      = bus.mem_rdata[DATA_WIDTH-1:COLOR_WIDTH];
  assign w_pass       = (r_z < w_z_old);
  assign w_last       = r_busy && (r_mem_addr == '1);
  assign w_clear_word = {{DEPTH_WIDTH{1'b1}}, CLEAR_COLOR};
  // r_rdy is only ever set in IDLE; masking it with clear_start means a
  // handshake can never coincide with a clear request that IDLE would favour.
  assign w_accept     = r_rdy && !bus.clear_start && bus.send_z_buffer;
  assign w_enter_clear = w_clear_req &&
                         ((r_state == S_IDLE) ||
                          (r_state == S_WRITE) ||
                          (r_state == S_COMPARE && !w_pass));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_rdy          <= 1'b0;
      r_pending      <= 1'b0;
      r_busy         <= 1'b0;
      r_rd_en        <= 1'b0;
      r_wr_en        <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_sweep        <= '0;
      r_addr         <= '0;
      r_z            <= '0;
      r_color        <= '0;
      r_cnt_written  <= '0;
      r_cnt_rejected <= '0;
    end else begin
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= bus.pix_in[PIXEL_WIDTH-1:DATA_WIDTH];
            r_z        <= bus.pix_in[DATA_WIDTH-1:COLOR_WIDTH];
            r_color    <= bus.pix_in[COLOR_WIDTH-1:0];
            r_rd_en    <= 1'b1;
            r_mem_addr <= bus.pix_in[PIXEL_WIDTH-1:DATA_WIDTH];
            r_rdy      <= 1'b0;
            r_state    <= S_READ;
          end else if (!w_clear_req) begin
            r_rdy <= 1'b1;
          end
        end
        S_READ: begin
          if (bus.clear_start) r_pending <= 1'b1;
          r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_pass) begin
            if (bus.clear_start) r_pending <= 1'b1;
            r_wr_en     <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= {r_z, r_color};
            r_state     <= S_WRITE;
          end else begin
            if (r_cnt_rejected != '1) r_cnt_rejected <= r_cnt_rejected + 16'd1;
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (r_cnt_written != '1) r_cnt_written <= r_cnt_written + 16'd1;
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_CLEAR: begin
          if (w_last) begin
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_sweep   <= '0;
            r_rdy     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_busy      <= 1'b1;
            r_wr_en     <= 1'b1;
            r_mem_addr  <= r_sweep;
            r_mem_wdata <= w_clear_word;
            r_sweep     <= r_sweep + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A pending or fresh clear request skips the idle cycle. The first sweep
      // write (address 0) is presented straight away, and the sweep counter
      // moves on to address 1.
      if (w_enter_clear) begin
        r_state     <= S_CLEAR;
        r_rdy       <= 1'b0;
        r_busy      <= 1'b1;
        r_wr_en     <= 1'b1;
        r_mem_addr  <= '0;
        r_mem_wdata <= w_clear_word;
        r_sweep     <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.rdy_z_buffer = r_rdy & ~bus.clear_start;
  assign bus.clear_busy   = r_busy;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_rd_en    = r_rd_en;
  assign bus.mem_wr_en    = r_wr_en;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.cnt_written  = r_cnt_written;
  assign bus.cnt_rejected = r_cnt_rejected;
endmodule

// File: tb/tb_zbuffer_ctrl.sv
// Self-checking bench for zbuffer_ctrl. It uses a behavioural shadow z-buffer
// and RAM model, directed and random pixels, and clear/reset interactions.
module tb_zbuffer_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zbuffer_ctrl_if #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW)) bus ();

  zbuffer_ctrl #(
    .ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW),
    .CLEAR_COLOR(8'h00), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Single-port synchronous RAM: read data one cycle after mem_rd_en.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Shadow of what the z-buffer should hold, plus expected counters.
  logic [7:0] ref_z [256];
  logic [7:0] ref_c [256];
  int exp_wr = 0;
  int exp_rej = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus rules that hold on every cycle.
  always @(negedge clk) begin
    check("rd_wr_exclusive", {31'd0, bus.mem_rd_en & bus.mem_wr_en}, 0);
    if (!bus.mem_rd_en && !bus.mem_wr_en) begin
      check("idle_addr_zero", {24'd0, bus.mem_addr}, 0);
      check("idle_wdata_zero", {16'd0, bus.mem_wdata}, 0);
    end
  end

  task automatic model_apply(input logic [7:0] a, input logic [7:0] z,
                             input logic [7:0] c, output bit pass);
    pass = (z < ref_z[a]);
    if (pass) begin
      ref_z[a] = z;
      ref_c[a] = c;
      if (exp_wr < 65535) exp_wr++;
    end else begin
      if (exp_rej < 65535) exp_rej++;
    end
  endtask

  task automatic check_reset_zero();
    check("rst_rdy", bus.rdy_z_buffer, 0);
    check("rst_busy", bus.clear_busy, 0);
    check("rst_rd", bus.mem_rd_en, 0);
    check("rst_wr", bus.mem_wr_en, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_cnt_wr", bus.cnt_written, 0);
    check("rst_cnt_rej", bus.cnt_rejected, 0);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (bus.rdy_z_buffer !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("rdy_timeout", bus.rdy_z_buffer, 1);
  endtask

  // Called at the negedge where sweep address 'start' should be presented.
  // A clear_start pulse is driven at pulse_at. Reset is asserted at reset_at,
  // which ends the task early.
  task automatic sweep(input int start, input int pulse_at, input int reset_at);
    for (int i = start; i < 256; i++) begin
      check("clr_busy", bus.clear_busy, 1);
      check("clr_wr", bus.mem_wr_en, 1);
      check("clr_addr", bus.mem_addr, i);
      check("clr_wdata", bus.mem_wdata, 32'hFF00);
      check("clr_rdy", bus.rdy_z_buffer, 0);
      ref_z[i] = 8'hFF;
      ref_c[i] = 8'h00;
      bus.clear_start = (i == pulse_at);
      if (i == reset_at) begin
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
    bus.clear_start = 1'b0;
    check("clr_done_busy", bus.clear_busy, 0);
    check("clr_done_wr", bus.mem_wr_en, 0);
    check("clr_done_rdy", bus.rdy_z_buffer, 1);
    @(negedge clk);
    check("no_reclear_busy", bus.clear_busy, 0);
    check("no_reclear_rdy", bus.rdy_z_buffer, 1);
  endtask

  task automatic do_pixel(input logic [7:0] a, input logic [7:0] z, input logic [7:0] c);
    bit pass;
    wait_rdy();
    bus.pix_in = {a, z, c};
    bus.send_z_buffer = 1'b1;
    model_apply(a, z, c, pass);
    @(posedge clk);
    @(negedge clk);
    bus.send_z_buffer = 1'b0;
    check("t1_rd_en", bus.mem_rd_en, 1);
    check("t1_rd_addr", bus.mem_addr, a);
    check("t1_rdy", bus.rdy_z_buffer, 0);
    @(negedge clk);
    check("t2_rd_en", bus.mem_rd_en, 0);
    check("t2_wr_en", bus.mem_wr_en, 0);
    check("t2_rdy", bus.rdy_z_buffer, 0);
    @(negedge clk);
    if (pass) begin
      check("t3_wr_en", bus.mem_wr_en, 1);
      check("t3_wr_addr", bus.mem_addr, a);
      check("t3_wdata", bus.mem_wdata, {z, c});
      check("t3_rdy_pass", bus.rdy_z_buffer, 0);
      @(negedge clk);
      check("t4_rdy", bus.rdy_z_buffer, 1);
      check("t4_wr_en", bus.mem_wr_en, 0);
    end else begin
      check("t3_no_wr", bus.mem_wr_en, 0);
      check("t3_rdy_rej", bus.rdy_z_buffer, 1);
    end
    check("cnt_written", bus.cnt_written, exp_wr);
    check("cnt_rejected", bus.cnt_rejected, exp_rej);
  endtask

  logic [23:0] q [4];
  int idx, nreads, nwrites;
  bit pass;

  initial begin
    bus.pix_in = '0;
    bus.send_z_buffer = 1'b0;
    bus.clear_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ref_z[i] = 8'h00;
      ref_c[i] = 8'h00;
    end

    // Reset, then the automatic clear sweep.
    repeat (3) @(negedge clk);
    check_reset_zero();
    reset = 1'b0;
    @(negedge clk);
    sweep(0, -1, -1);

    // Directed depth tests, including equal depth.
    do_pixel(8'h10, 8'h40, 8'hAA);
    do_pixel(8'h10, 8'h40, 8'h55);
    do_pixel(8'h10, 8'h50, 8'h55);
    do_pixel(8'h10, 8'h3F, 8'h55);

    // Random pixels over a small address range so that depths collide.
    repeat (40) do_pixel(8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                         8'($urandom));

    // Tree holds send high with four pixels queued.
    q[0] = {8'h30, 8'h10, 8'h01};
    q[1] = {8'h30, 8'h20, 8'h02};
    q[2] = {8'h31, 8'h05, 8'h03};
    q[3] = {8'h30, 8'h10, 8'h04};
    wait_rdy();
    idx = 0; nreads = 0; nwrites = 0;
    bus.pix_in = q[0];
    bus.send_z_buffer = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus.mem_wr_en) nwrites++;
      if (bus.mem_rd_en) begin
        nreads++;
        if (idx < 4) begin
          check("stream_addr", bus.mem_addr, q[idx][23:16]);
          model_apply(q[idx][23:16], q[idx][15:8], q[idx][7:0], pass);
          idx++;
          if (idx < 4) bus.pix_in = q[idx];
          else bus.send_z_buffer = 1'b0;
        end
      end
    end
    bus.send_z_buffer = 1'b0;
    check("stream_reads", nreads, 4);
    check("stream_writes", nwrites, 2);
    check("stream_cnt_wr", bus.cnt_written, exp_wr);
    check("stream_cnt_rej", bus.cnt_rejected, exp_rej);

    // clear_start during COMPARE of a passing pixel.
    wait_rdy();
    bus.pix_in = {8'hEE, 8'h00, 8'h77};
    bus.send_z_buffer = 1'b1;
    model_apply(8'hEE, 8'h00, 8'h77, pass);
    @(posedge clk);
    @(negedge clk);
    bus.send_z_buffer = 1'b0;
    @(negedge clk);
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    check("cc_wr_en", bus.mem_wr_en, 1);
    check("cc_wr_addr", bus.mem_addr, 8'hEE);
    check("cc_wdata", bus.mem_wdata, 16'h0077);
    check("cc_rdy", bus.rdy_z_buffer, 0);
    @(negedge clk);
    sweep(0, 10, -1);
    check("cc_cnt_wr", bus.cnt_written, exp_wr);

    // Reset during WRITE.
    wait_rdy();
    bus.pix_in = {8'h20, 8'h01, 8'h99};
    bus.send_z_buffer = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send_z_buffer = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rw_wr_en", bus.mem_wr_en, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_zero();
    reset = 1'b0;
    exp_wr = 0;
    exp_rej = 0;
    @(negedge clk);

    // Reset mid-sweep at address 0x80, then a full sweep from 0.
    sweep(0, -1, 8'h80);
    @(negedge clk);
    check_reset_zero();
    reset = 1'b0;
    @(negedge clk);
    sweep(0, -1, -1);

    do_pixel(8'h10, 8'h40, 8'hAA);
    do_pixel(8'h10, 8'h41, 8'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
